// File: rtl/sram_controller_pkg.sv
// ============================================================================
// Module   : sram_controller_pkg
// Brief    : Shared types and constants for the 16-bit async SRAM controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          c_sram_dw   = 16;
  localparam int          c_sram_aw   = 18;
  localparam logic [31:0] c_base_addr = 32'd1024;

endpackage

`default_nettype wire

// File: rtl/sram_controller_if.sv
// ============================================================================
// Module   : sram_controller_if
// Brief    : MEM-stage request/response bundle between pipeline and controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module   : sram_controller
// Brief    : Splits 32-bit MEM-stage accesses into two 16-bit async SRAM cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = c_base_addr,
  parameter int          ACCESS_CYCLES = 2,
  parameter int          SRAM_AW       = c_sram_aw
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  sram_controller_if.slave          bus,
  inout  wire logic [c_sram_dw-1:0] SRAM_DQ,
  output logic      [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                      SRAM_WE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_UB_N,
  output logic                      SRAM_LB_N
);

  localparam logic [3:0] c_last = 4'(ACCESS_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_next;
  logic                 r_is_write;
  logic [SRAM_AW-2:0]   r_word_idx;
  logic [31:0]          r_wdata;
  logic [31:0]          r_read_data;

  logic                 w_req;
  logic                 w_last;
  logic                 w_active;
  logic                 w_latch;
  logic                 w_cap_lo;
  logic                 w_cap_hi;
  logic                 w_ready;
  logic                 w_dq_oe;
  logic [c_sram_dw-1:0] w_dq_out;
  logic [31:0]          w_offset;
  logic [SRAM_AW-2:0]   w_word_idx;
  logic [33-SRAM_AW:0]  w_unused_offset;

  assign w_req      = bus.rd_en | bus.wr_en;
  assign w_last     = (r_cnt == c_last);
  // Out-of-range addresses wrap silently: only SRAM_AW-1 word-index bits survive.
  assign w_offset   = bus.address - BASE_ADDR;
  assign w_word_idx = w_offset[SRAM_AW:2];
  assign w_unused_offset = {w_offset[31:SRAM_AW+1], w_offset[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_is_write  <= 1'b0;
      r_word_idx  <= '0;
      r_wdata     <= 32'd0;
      r_read_data <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_is_write <= bus.wr_en;
        r_word_idx <= w_word_idx;
        r_wdata    <= bus.write_data;
      end
      if (w_cap_lo) r_read_data[15:0]  <= SRAM_DQ;
      if (w_cap_hi) r_read_data[31:16] <= SRAM_DQ;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ready      = 1'b0;
    w_latch      = 1'b0;
    w_active     = 1'b0;
    w_cap_lo     = 1'b0;
    w_cap_hi     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~w_req;
        if (w_req) begin
          w_latch      = 1'b1;
          w_state_next = LOW;
          w_cnt_next   = 4'd0;
        end
      end
      LOW: begin
        w_active = 1'b1;
        if (w_last) begin
          w_state_next = HIGH;
          w_cnt_next   = 4'd0;
          w_cap_lo     = ~r_is_write;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      HIGH: begin
        w_active = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
          w_cnt_next   = 4'd0;
          w_cap_hi     = ~r_is_write;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      DONE: begin
        w_ready      = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  // WE_N rises on the last cycle of each phase so address/data stay valid past the write edge.
  always_comb begin
    SRAM_WE_N = ~(w_active & r_is_write & ~w_last);
    SRAM_OE_N = ~(w_active & ~r_is_write);
    SRAM_ADDR = {r_word_idx, (r_state == HIGH)};
    w_dq_oe   = w_active & r_is_write;
    w_dq_out  = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
  end

  assign SRAM_DQ       = w_dq_oe ? w_dq_out : 'z;
  assign SRAM_CE_N     = 1'b0;
  assign SRAM_UB_N     = 1'b0;
  assign SRAM_LB_N     = 1'b0;
  assign bus.ready     = w_ready;
  assign bus.read_data = r_read_data;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// Module   : tb_sram_controller
// Brief    : Directed vector bench for sram_controller with a behavioural SRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_controller_if bus ();

  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  sram_controller #(
    .BASE_ADDR     (32'd1024),
    .ACCESS_CYCLES (2),
    .SRAM_AW       (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

  // sram_model: 2^18 x 16 async SRAM, write on WE_N rising edge, combinational read.
  logic [15:0] mem [0:(1<<18)-1];
  assign SRAM_DQ = (!SRAM_OE_N) ? mem[SRAM_ADDR] : 16'bz;
  always @(posedge SRAM_WE_N) if (!rst) mem[SRAM_ADDR] <= SRAM_DQ;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        scr;     // disturb inputs after the request is latched
    logic        b2b;     // next access follows straight after DONE
    int          word;    // expected SRAM word index
    logic [31:0] exp_rd;  // read_data expected in DONE and afterwards
  } vec_t;

  vec_t vecs [8];

  task automatic run_access(input vec_t v);
    int frz;
    bit done;
    frz  = 0;
    done = 0;
    bus.wr_en      = v.wr;
    bus.rd_en      = v.rd;
    bus.address    = v.addr;
    bus.write_data = v.wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!bus.ready) begin
        frz++;
        if (frz >= 2 && frz <= 5) begin
          check("sram_addr", 32'(SRAM_ADDR), 32'(2 * v.word + ((frz >= 4) ? 1 : 0)));
          check("strobes_we_oe", {30'd0, SRAM_WE_N, SRAM_OE_N},
                v.wr ? {30'd0, (frz == 3 || frz == 5), 1'b1} : 32'd2);
          if (v.wr && (frz == 2 || frz == 4))
            check("dq_drive", {16'd0, SRAM_DQ},
                  {16'd0, (frz == 2) ? v.wdata[15:0] : v.wdata[31:16]});
          if (v.scr && frz == 2) begin
            bus.address    = bus.address ^ 32'h40;
            bus.write_data = ~bus.write_data;
            bus.rd_en      = ~bus.rd_en;
          end
        end
      end else if (frz > 0) begin
        done = 1;
        check("freeze_len", 32'(frz), 32'd5);
        check("rdata_done", bus.read_data, v.exp_rd);
      end
    end
    if (!done) check("access_timeout", 32'(frz), 32'd5);
    @(posedge clk); #1;
    if (!v.b2b) begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      @(negedge clk);
      check("ready_idle", {31'd0, bus.ready}, 32'd1);
      check("rdata_held", bus.read_data, v.exp_rd);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t vr;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.address    = 32'd0;
    bus.write_data = 32'd0;

    vecs[0] = '{1'b1, 1'b0, 32'd1024,      32'hDEADBEEF, 1'b0, 1'b0, 0, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024,      32'h00000000, 1'b0, 1'b0, 0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1028,      32'h12345678, 1'b0, 1'b1, 1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1028,      32'h00000000, 1'b0, 1'b0, 1, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'd1032,      32'hA5A5A5A5, 1'b0, 1'b0, 2, 32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'd1032,      32'h00000000, 1'b0, 1'b0, 2, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, 1'b0, 32'h00080400,  32'hCAFEF00D, 1'b1, 1'b0, 0, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 1'b1, 32'd1024,      32'h00000000, 1'b1, 1'b0, 0, 32'hCAFEF00D};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {31'd0, bus.ready}, 32'd1);
    check("rst_we_oe",  {30'd0, SRAM_WE_N, SRAM_OE_N}, 32'd3);
    check("rst_addr",   32'(SRAM_ADDR), 32'd0);
    check("rst_rdata",  bus.read_data, 32'd0);
    check("tied_lo",    {29'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i]);
      if (i == 0) begin
        check("mem_w0_first", {16'd0, mem[0]}, 32'h0000BEEF);
        check("mem_w1_first", {16'd0, mem[1]}, 32'h0000DEAD);
      end
    end

    check("mem_w0_wrap", {16'd0, mem[0]}, 32'h0000F00D);
    check("mem_w1_wrap", {16'd0, mem[1]}, 32'h0000CAFE);
    check("mem_w2",      {16'd0, mem[2]}, 32'h00005678);
    check("mem_w3",      {16'd0, mem[3]}, 32'h00001234);
    check("mem_w4",      {16'd0, mem[4]}, 32'h0000A5A5);
    check("mem_w5",      {16'd0, mem[5]}, 32'h0000A5A5);

    // Reset in the middle of a write's LOW phase.
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1040;
    bus.write_data = 32'h5555AAAA;
    @(negedge clk);
    @(negedge clk);
    check("mid_we_low", {31'd0, SRAM_WE_N}, 32'd0);
    rst = 1'b1;
    #1;
    check("async_we_oe", {30'd0, SRAM_WE_N, SRAM_OE_N}, 32'd3);
    check("async_rdata", bus.read_data, 32'd0);
    check("async_addr",  32'(SRAM_ADDR), 32'd0);
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("rst_idle_ready", {31'd0, bus.ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    vr = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 1'b0, 1'b0, 0, 32'hCAFEF00D};
    run_access(vr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
